// File: rtl/row_clear_engine_if.sv
// rtl/row_clear_engine_if.sv - request/result bundle between a board owner and row_clear_engine
interface row_clear_engine_if #(
   parameter int COLS   = 10,
   parameter int ROWS   = 20,
   parameter int CELL_W = 3
);
   localparam int BW = COLS * ROWS * CELL_W;

   logic          start;
   logic [BW-1:0] cur_board;
   logic          busy;
   logic          done;
   logic [BW-1:0] nxt_board;
   logic [4:0]    num_cleared;
`ifdef ROW_CLEAR_SCORE_EN
   logic [15:0]   score;

   modport master (output start, cur_board,
                   input  busy, done, nxt_board, num_cleared, score);
   modport slave  (input  start, cur_board,
                   output busy, done, nxt_board, num_cleared, score);
`else
   modport master (output start, cur_board,
                   input  busy, done, nxt_board, num_cleared);
   modport slave  (input  start, cur_board,
                   output busy, done, nxt_board, num_cleared);
`endif
endinterface

// File: rtl/row_clear_engine.sv
// rtl/row_clear_engine.sv - removes full rows from a board snapshot, one row per cycle
// Optional score output enabled by macro ROW_CLEAR_SCORE_EN.
module row_clear_engine #(
   parameter int COLS   = 10,
   parameter int ROWS   = 20,
   parameter int CELL_W = 3
) (
   input  logic              main_clk,
   input  logic              rst_1plus,
   row_clear_engine_if.slave bus
);
   localparam int ROW_W = COLS * CELL_W;
   localparam int BW    = ROW_W * ROWS;
   localparam int IW    = $clog2(ROWS + 1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [BW-1:0]    src;
   logic [BW-1:0]    work;
   logic [BW-1:0]    nxt_board_q;
   logic [IW-1:0]    rd;
   logic [IW-1:0]    wr;
   logic [4:0]       count;
   logic [4:0]       num_cleared_q;
   logic             done_q;
   logic             busy_c;
   logic             last_row;
   logic             row_full;
   logic [ROW_W-1:0] src_row;

   always_ff @(posedge main_clk or posedge rst_1plus) begin
      if (rst_1plus) state <= IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = SCAN;
         SCAN:    if (last_row)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy_c   = (state != IDLE);
      last_row = (rd == IW'(ROWS - 1));
      src_row  = src[rd * ROW_W +: ROW_W];
      row_full = 1'b1;
      for (int c = 0; c < COLS; c++) begin
         if (src_row[c * CELL_W +: CELL_W] == '0) row_full = 1'b0;
      end
   end

`ifdef ROW_CLEAR_SCORE_EN
   logic [15:0] score_q;
   logic [10:0] points;
   logic [16:0] score_sum;

   always_comb begin
      case (count)
         5'd0:    points = 11'd0;
         5'd1:    points = 11'd40;
         5'd2:    points = 11'd100;
         5'd3:    points = 11'd300;
         default: points = 11'd1200;
      endcase
      score_sum = {1'b0, score_q} + {6'd0, points};
   end

   always_ff @(posedge main_clk or posedge rst_1plus) begin
      if (rst_1plus)          score_q <= '0;
      else if (state == DONE) score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
   end

   assign bus.score = score_q;
`endif

   // The work board starts zeroed, so rows never written become the empty top rows.
   always_ff @(posedge main_clk or posedge rst_1plus) begin
      if (rst_1plus) begin
         src           <= '0;
         work          <= '0;
         rd            <= '0;
         wr            <= '0;
         count         <= '0;
         nxt_board_q   <= '0;
         num_cleared_q <= '0;
         done_q        <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  src   <= bus.cur_board;
                  work  <= '0;
                  rd    <= '0;
                  wr    <= '0;
                  count <= '0;
               end
            end
            SCAN: begin
               if (row_full) begin
                  count <= count + 5'd1;
               end else begin
                  work[wr * ROW_W +: ROW_W] <= src_row;
                  wr <= wr + IW'(1);
               end
               if (!last_row) rd <= rd + IW'(1);
            end
            DONE: begin
               nxt_board_q   <= work;
               num_cleared_q <= count;
               done_q        <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = busy_c;
   assign bus.done        = done_q;
   assign bus.nxt_board   = nxt_board_q;
   assign bus.num_cleared = num_cleared_q;
endmodule
